// File: rtl/vga_disc_pkg.sv
// Shared types and constants for the VGA disc scheduler: FSM states,
// compositing modes, RGB bit offsets and a lowest-set-bit helper.
package vga_disc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ADVANCE
  } state_t;

  localparam int BLEND_PRIORITY = 0;
  localparam int BLEND_OR       = 1;

  localparam int RGB_W     = 3;
  localparam int RGB_R_OFS = 2;
  localparam int RGB_G_OFS = 1;
  localparam int RGB_B_OFS = 0;

  localparam int MAX_DISCS = 8;

  // Scanning from the top down leaves the lowest set bit as the final winner.
  function automatic logic [2:0] lowest_set(input logic [MAX_DISCS-1:0] m);
    lowest_set = '0;
    for (int i = MAX_DISCS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/disc_next_index.sv
// Round-robin successor search: next set mask bit strictly above the current
// index, wrapping to the lowest set bit; flags the wrap and an empty mask.
module disc_next_index
  import vga_disc_pkg::*;
#(
  parameter int NUM_DISCS = 3
) (
  input  logic [NUM_DISCS-1:0]                   mask_i,
  input  logic [((NUM_DISCS > 1) ? $clog2(NUM_DISCS) : 1)-1:0] cur_i,
  output logic [((NUM_DISCS > 1) ? $clog2(NUM_DISCS) : 1)-1:0] next_o,
  output logic                                   wrap_o,
  output logic                                   none_o
);

  localparam int IDX_W = (NUM_DISCS > 1) ? $clog2(NUM_DISCS) : 1;

  logic found;

  always_comb begin
    found  = 1'b0;
    next_o = '0;
    none_o = (mask_i == '0);
    for (int i = NUM_DISCS - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(cur_i))) begin
        next_o = IDX_W'(i);
        found  = 1'b1;
      end
    end
    // Nothing above the current index: fall back to the lowest set bit.
    if (!found) begin
      for (int i = NUM_DISCS - 1; i >= 0; i--) begin
        if (mask_i[i]) next_o = IDX_W'(i);
      end
    end
    wrap_o = !found && !none_o;
  end

endmodule

// File: rtl/vga_disc_scheduler.sv
// Round-robin multiply-grant scheduler for disc channels with per-grant
// timeout, plus a registered priority / OR-blend pixel compositor.
module vga_disc_scheduler
  import vga_disc_pkg::*;
#(
  parameter int NUM_DISCS      = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BLEND_MODE     = 0,
  parameter int IDX_W          = (NUM_DISCS > 1) ? $clog2(NUM_DISCS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       locked,
  input  logic                       blank,
  input  logic [NUM_DISCS-1:0]       disc_mask,
  input  logic [RGB_W*NUM_DISCS-1:0] disc_color,
  input  logic [NUM_DISCS-1:0]       flag_on_disc,
  input  logic [NUM_DISCS-1:0]       mul_done,
  output logic [NUM_DISCS-1:0]       mul_enable,
  output logic                       red,
  output logic                       green,
  output logic                       blue,
  output logic [IDX_W-1:0]           active_idx,
  output logic                       sweep_done,
  output logic                       timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_DISCS-1:0] men_q, men_d;
  logic                 terr_q, terr_d;
  logic [RGB_W-1:0]     rgb_q, rgb_d;

  logic [IDX_W-1:0]     nxt_idx;
  logic                 nxt_wrap;
  logic                 nxt_none;
  logic [IDX_W-1:0]     low_idx;
  logic [NUM_DISCS-1:0] contrib;

  disc_next_index #(
    .NUM_DISCS(NUM_DISCS)
  ) u_next (
    .mask_i(disc_mask),
    .cur_i (idx_q),
    .next_o(nxt_idx),
    .wrap_o(nxt_wrap),
    .none_o(nxt_none)
  );

  assign low_idx = IDX_W'(lowest_set(MAX_DISCS'(disc_mask)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    men_d   = men_q;
    terr_d  = terr_q;
    if (!locked) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      men_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          men_d = '0;
          if (|disc_mask) begin
            idx_d   = low_idx;
            men_d   = NUM_DISCS'(1) << low_idx;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          cnt_d = cnt_q + CNT_W'(1);
          // A done arriving on the timeout cycle wins and leaves the error flag alone.
          if (mul_done[idx_q]) begin
            state_d = S_ADVANCE;
            cnt_d   = '0;
            men_d   = '0;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            terr_d  = 1'b1;
            state_d = S_ADVANCE;
            cnt_d   = '0;
            men_d   = '0;
          end
        end
        S_ADVANCE: begin
          cnt_d = '0;
          men_d = '0;
          if (nxt_none) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = nxt_idx;
            men_d   = NUM_DISCS'(1) << nxt_idx;
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
          men_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    contrib = flag_on_disc & disc_mask;
    rgb_d   = '0;
    if (BLEND_MODE == BLEND_OR) begin
      for (int i = 0; i < NUM_DISCS; i++) begin
        if (contrib[i]) rgb_d = rgb_d | disc_color[RGB_W*i +: RGB_W];
      end
    end else begin
      for (int i = NUM_DISCS - 1; i >= 0; i--) begin
        if (contrib[i]) rgb_d = disc_color[RGB_W*i +: RGB_W];
      end
    end
    if (blank) rgb_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      men_q   <= '0;
      terr_q  <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      men_q   <= men_d;
      terr_q  <= terr_d;
      rgb_q   <= rgb_d;
    end
  end

  assign mul_enable  = men_q;
  assign active_idx  = idx_q;
  assign timeout_err = terr_q;
  assign sweep_done  = (state_q == S_ADVANCE) && nxt_wrap;
  assign red         = rgb_q[RGB_R_OFS];
  assign green       = rgb_q[RGB_G_OFS];
  assign blue        = rgb_q[RGB_B_OFS];

endmodule

// File: tb/tb_vga_disc_scheduler.sv
// Directed scoreboard bench: dut0 (TIMEOUT 8, priority blend) drives the
// scheduler checks, dut1 (OR blend) shares inputs for compositing checks.
module tb_vga_disc_scheduler;

  logic       clk;
  logic       reset;
  logic       locked;
  logic       blank;
  logic [2:0] disc_mask;
  logic [8:0] disc_color;
  logic [2:0] flag_on_disc;
  logic [2:0] mul_done;

  logic [2:0] men0, men1;
  logic       r0, g0, b0, r1, g1, b1;
  logic [1:0] idx0, idx1;
  logic       sweep0, sweep1, terr0, terr1;

  int errors = 0;
  int checks = 0;

  logic [1:0] grantQ[$];
  logic       sweepQ[$];
  logic [5:0] colQ[$];

  vga_disc_scheduler #(.NUM_DISCS(3), .TIMEOUT_CYCLES(8), .BLEND_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .locked(locked), .blank(blank),
    .disc_mask(disc_mask), .disc_color(disc_color), .flag_on_disc(flag_on_disc),
    .mul_done(mul_done), .mul_enable(men0), .red(r0), .green(g0), .blue(b0),
    .active_idx(idx0), .sweep_done(sweep0), .timeout_err(terr0)
  );

  vga_disc_scheduler #(.NUM_DISCS(3), .TIMEOUT_CYCLES(1024), .BLEND_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .locked(locked), .blank(blank),
    .disc_mask(disc_mask), .disc_color(disc_color), .flag_on_disc(flag_on_disc),
    .mul_done(mul_done), .mul_enable(men1), .red(r1), .green(g1), .blue(b1),
    .active_idx(idx1), .sweep_done(sweep1), .timeout_err(terr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the next queued grant, probes it, returns done after four cycles.
  task automatic serveGrant(input int expWait, input logic [2:0] midMask);
    int         waited;
    logic [1:0] expIdx;
    logic       expSweep;
    waited   = 0;
    expIdx   = grantQ.pop_front();
    expSweep = sweepQ.pop_front();
    while (men0 == '0 && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("grantWait", 32'(waited), 32'(expWait));
    checkOutput("grantOneHot", 32'(men0), 32'(3'b001 << expIdx));
    checkOutput("activeIdx", 32'(idx0), 32'(expIdx));
    disc_mask = midMask;
    mul_done  = ~(3'b001 << expIdx);
    tick();
    mul_done = '0;
    checkOutput("ignoreOtherDone", 32'(men0), 32'(3'b001 << expIdx));
    tick();
    tick();
    tick();
    mul_done = 3'b001 << expIdx;
    tick();
    mul_done = '0;
    checkOutput("advanceNoGrant", 32'(men0), 32'(0));
    checkOutput("sweepDone", 32'(sweep0), 32'(expSweep));
    tick();
  endtask

  task automatic applyStimulus(input logic [2:0] m, input logic [2:0] f, input logic b,
                               input logic [2:0] exp0, input logic [2:0] exp1);
    disc_mask    = m;
    flag_on_disc = f;
    blank        = b;
    colQ.push_back({exp0, exp1});
    tick();
  endtask

  task automatic checkColour(input string tag);
    logic [5:0] e;
    e = colQ.pop_front();
    checkOutput({tag, "_prio"}, 32'({r0, g0, b0}), 32'(e[5:3]));
    checkOutput({tag, "_or"}, 32'({r1, g1, b1}), 32'(e[2:0]));
  endtask

  initial begin
    int hi;
    reset        = 1'b1;
    locked       = 1'b0;
    blank        = 1'b0;
    disc_mask    = '0;
    disc_color   = 9'b001_010_100;
    flag_on_disc = '0;
    mul_done     = '0;
    tick();
    tick();
    checkOutput("rstMulEnable", 32'(men0), 32'(0));
    checkOutput("rstIdx", 32'(idx0), 32'(0));
    checkOutput("rstSweep", 32'(sweep0), 32'(0));
    checkOutput("rstTimeout", 32'(terr0), 32'(0));
    checkOutput("rstRgb", 32'({r0, g0, b0}), 32'(0));
    reset = 1'b0;

    // Round robin over all three discs
    disc_mask = 3'b111;
    locked    = 1'b1;
    grantQ.push_back(2'd0); sweepQ.push_back(1'b0);
    grantQ.push_back(2'd1); sweepQ.push_back(1'b0);
    grantQ.push_back(2'd2); sweepQ.push_back(1'b1);
    grantQ.push_back(2'd0); sweepQ.push_back(1'b0);
    serveGrant(1, 3'b111);
    serveGrant(0, 3'b111);
    serveGrant(0, 3'b111);
    serveGrant(0, 3'b111);
    checkOutput("rrNextGrant", 32'(men0), 32'(3'b010));
    locked = 1'b0;
    tick();
    checkOutput("unlockMulEnable", 32'(men0), 32'(0));
    checkOutput("unlockIdxHold", 32'(idx0), 32'(1));

    // Masked discs, then drop disc 2 during its own grant
    disc_mask = 3'b101;
    locked    = 1'b1;
    grantQ.push_back(2'd0); sweepQ.push_back(1'b0);
    grantQ.push_back(2'd2); sweepQ.push_back(1'b1);
    grantQ.push_back(2'd0); sweepQ.push_back(1'b0);
    grantQ.push_back(2'd2); sweepQ.push_back(1'b1);
    grantQ.push_back(2'd0); sweepQ.push_back(1'b1);
    grantQ.push_back(2'd0); sweepQ.push_back(1'b1);
    serveGrant(1, 3'b101);
    serveGrant(0, 3'b101);
    serveGrant(0, 3'b101);
    serveGrant(0, 3'b001);
    serveGrant(0, 3'b001);
    serveGrant(0, 3'b001);
    locked = 1'b0;
    tick();
    checkOutput("maskUnlock", 32'(men0), 32'(0));

    // Timeout on disc 1, grant moves on to disc 2
    disc_mask    = 3'b110;
    flag_on_disc = 3'b010;
    locked       = 1'b1;
    tick();
    checkOutput("toGrant", 32'(men0), 32'(3'b010));
    hi = 0;
    while (men0[1] && hi < 20) begin
      hi++;
      tick();
    end
    checkOutput("toGrantCycles", 32'(hi), 32'(8));
    checkOutput("toAdvance", 32'(men0), 32'(0));
    checkOutput("toErrSet", 32'(terr0), 32'(1));
    checkOutput("toNoWrap", 32'(sweep0), 32'(0));
    tick();
    grantQ.push_back(2'd2); sweepQ.push_back(1'b1);
    serveGrant(0, 3'b110);
    checkOutput("toErrSticky", 32'(terr0), 32'(1));
    checkOutput("rgbBeforeReset", 32'({r0, g0, b0}), 32'(3'b010));

    // Reset mid-grant of disc 1
    checkOutput("preResetGrant", 32'(men0), 32'(3'b010));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midRstMulEnable", 32'(men0), 32'(0));
    checkOutput("midRstIdx", 32'(idx0), 32'(0));
    checkOutput("midRstTimeout", 32'(terr0), 32'(0));
    checkOutput("midRstSweep", 32'(sweep0), 32'(0));
    checkOutput("midRstRgb", 32'({r0, g0, b0}), 32'(0));

    // Restart at lowest set bit; done lands on the eighth grant cycle
    tick();
    checkOutput("restartGrant", 32'(men0), 32'(3'b010));
    checkOutput("restartIdx", 32'(idx0), 32'(1));
    for (int k = 0; k < 7; k++) tick();
    checkOutput("lastCycleGrant", 32'(men0), 32'(3'b010));
    mul_done = 3'b010;
    tick();
    mul_done = '0;
    checkOutput("doneAtLimitAdvance", 32'(men0), 32'(0));
    checkOutput("doneAtLimitNoErr", 32'(terr0), 32'(0));
    tick();
    checkOutput("doneAtLimitNext", 32'(men0), 32'(3'b100));
    locked = 1'b0;
    tick();
    checkOutput("finalUnlock", 32'(men0), 32'(0));
    checkOutput("finalIdxHold", 32'(idx0), 32'(2));

    // Compositing: disc0 red, disc1 green, disc2 blue
    applyStimulus(3'b111, 3'b011, 1'b0, 3'b100, 3'b110);
    checkColour("colFlags011");
    applyStimulus(3'b111, 3'b011, 1'b1, 3'b000, 3'b000);
    checkColour("colBlank");
    applyStimulus(3'b110, 3'b011, 1'b0, 3'b010, 3'b010);
    checkColour("colMaskGate");
    applyStimulus(3'b111, 3'b000, 1'b0, 3'b000, 3'b000);
    checkColour("colNone");
    applyStimulus(3'b111, 3'b101, 1'b0, 3'b100, 3'b101);
    checkColour("colFlags101");
    applyStimulus(3'b111, 3'b110, 1'b0, 3'b010, 3'b011);
    checkColour("colFlags110");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_disc_scheduler.md
VGA_DISC_SCHEDULER -- requirements
Module: vga_disc_scheduler

Interface
REQ-001 SHALL have parameter NUM_DISCS, default 3, number of disc channels (legal 1..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles per grant before forced advance (legal >= 2).
REQ-003 SHALL have parameter BLEND_MODE, default 0, colour compositing mode: 0 = priority, 1 = OR-blend.
REQ-004 SHALL derive IDX_W = max(1, $clog2(NUM_DISCS)).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports, listed as name, direction, width, meaning:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- locked  in  1  clock-wizard lock; scheduler runs only while high
- blank  in  1  video blanking; forces black output
- disc_mask  in  NUM_DISCS  per-disc enable
- disc_color  in  3*NUM_DISCS  per-disc RGB; bits [3i+2]=R, [3i+1]=G, [3i]=B
- flag_on_disc  in  NUM_DISCS  current pixel inside disc i
- mul_done  in  NUM_DISCS  disc i finished its multiply
- mul_enable  out  NUM_DISCS  one-hot multiply grant
- red, green, blue  out  1 each  registered pixel colour
- active_idx  out  IDX_W  index currently granted
- sweep_done  out  1  one-cycle pulse when a grant round wraps
- timeout_err  out  1  sticky: a grant timed out

Function
REQ-007 SHALL implement states S_IDLE, S_RUN, S_ADVANCE.
REQ-008 S_IDLE: mul_enable = 0; when locked=1 and |disc_mask=1, SHALL set active_idx to the lowest set mask bit and enter S_RUN on the next cycle.
REQ-009 S_RUN: mul_enable SHALL equal 1<<active_idx (registered); the grant counter increments every cycle starting from 0.
REQ-010 In S_RUN, mul_done[active_idx]=1 SHALL cause S_ADVANCE next cycle, with mul_enable=0 from that cycle.
REQ-011 In S_RUN, counter = TIMEOUT_CYCLES-1 with no mul_done SHALL set timeout_err and cause S_ADVANCE next cycle.
REQ-012 mul_done and timeout in the same cycle SHALL count as done; timeout_err stays unchanged.
REQ-013 mul_done bits other than active_idx SHALL be ignored.
REQ-014 S_ADVANCE SHALL last exactly one cycle with mul_enable=0.
- Sample disc_mask in this cycle.
- Next index = next set bit strictly above active_idx, wrapping to the lowest set bit.
- Counter clears.
- Then enter S_RUN, or S_IDLE if the mask is empty.
REQ-015 sweep_done SHALL pulse for one cycle in S_ADVANCE when the next index is <= the current index (wrap), including the single-enabled-disc case.
REQ-016 disc_mask changes during S_RUN SHALL NOT abort the current grant.
REQ-017 locked=0 in any state SHALL force S_IDLE on the next cycle and clear mul_enable and the counter; active_idx holds.
REQ-018 Colour path SHALL have 1-cycle latency; a contributing disc is any i with flag_on_disc[i] & disc_mask[i].
REQ-019 BLEND_MODE=0: output SHALL be the disc_color of the lowest-index contributing disc.
REQ-020 BLEND_MODE=1: output SHALL be the bitwise OR of all contributing disc_colors.
REQ-021 No contributor, or blank=1, SHALL yield red=green=blue=0 on the next cycle.
REQ-022 The colour path SHALL operate regardless of scheduler state.

Reset
REQ-023 reset=1 at a clk edge SHALL force these values on the next cycle, overriding all other inputs, including mid-grant:
- state S_IDLE
- active_idx 0, counter 0
- mul_enable 0
- red/green/blue 0
- sweep_done 0, timeout_err 0
REQ-024 timeout_err SHALL clear only on reset.

Structure
REQ-025 State enum state_t, constants BLEND_PRIORITY=0 and BLEND_OR=1, and RGB bit-offset constants SHALL reside in shared package vga_disc_pkg.
REQ-026 The next-index search SHALL be a sub-module disc_next_index, parameterised by NUM_DISCS, with inputs mask and current index and outputs next index, wrap flag and none flag.

Verification
REQ-027 Round-robin: mask=3'b111, locked=1, each done returned 4 cycles after grant -> grants 0,1,2,0 with a 1-cycle gap between grants; sweep_done pulses once per wrap.
REQ-028 Masking: mask=3'b101 -> grants alternate 0,2. Clear bit 2 mid-grant of 2 -> grant 2 completes, then only 0 is granted and sweep_done pulses every advance.
REQ-029 Timeout: TIMEOUT_CYCLES=8, disc 1 never done -> mul_enable[1] high exactly 8 cycles, then timeout_err=1 (sticky) and grant moves to 2. Done on cycle 8 -> timeout_err stays 0.
REQ-030 Compositing: flags=3'b011, colors 0:R, 1:G -> BLEND_MODE=0 gives 100, BLEND_MODE=1 gives 110, both one cycle later; blank=1 gives 000.
REQ-031 Lock/reset: locked drops mid-grant -> mul_enable=0 next cycle, state S_IDLE. reset mid-grant -> all outputs 0 next cycle; with locked=1 and mask nonzero, granting restarts at the lowest set bit.
